// File: rtl/sdd_pkg.sv
// Shared types and defaults for the sum/difference decoder.
package sdd_pkg;

    localparam int unsigned SDD_WIDTH = 4;
    localparam int unsigned SDD_ERRW  = 8;

    // Queue occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sdd_occ_e;

    // Queue entry at the default operand width.
    typedef struct packed {
        logic [SDD_WIDTH-1:0] a;
        logic [SDD_WIDTH-1:0] b;
        logic                 err;
    } sdd_entry_t;

endpackage

// File: rtl/sdd_fifo2.sv
// Two-entry queue with a registered input ready and a struct payload.
// The head entry drives the outputs directly from registers.
module sdd_fifo2
    import sdd_pkg::*;
#(
    parameter type entry_t = sdd_entry_t
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_push_valid,
    output logic   o_push_ready,
    input  entry_t i_push_data,
    output logic   o_pop_valid,
    input  logic   i_pop_ready,
    output entry_t o_pop_data
);

    sdd_occ_e r_state;
    entry_t   r_head;
    entry_t   r_tail;
    logic     r_in_ready;
    logic     r_out_valid;

    logic w_push;
    logic w_pop;

    assign w_push = i_push_valid && r_in_ready;
    assign w_pop  = r_out_valid && i_pop_ready;

    // Occupancy FSM; ready and valid are registered alongside the next state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_push) begin
                        r_head      <= i_push_data;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        // Head leaves, new word takes its place.
                        r_head <= i_push_data;
                    end else if (w_push) begin
                        r_tail      <= i_push_data;
                        r_state     <= FULL;
                        r_in_ready  <= 1'b0;
                    end else if (w_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_head     <= r_tail;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_push_ready = r_in_ready;
    assign o_pop_valid  = r_out_valid;
    assign o_pop_data   = r_head;

endmodule

// File: rtl/sum_diff_decoder.sv
// Recovers a and b from (a+b, a-b) words, flags parity-inconsistent words,
// buffers results in a 2-entry queue and counts accepted error words.
module sum_diff_decoder
    import sdd_pkg::*;
#(
    parameter int unsigned WIDTH = SDD_WIDTH,
    parameter int unsigned ERRW  = SDD_ERRW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [WIDTH:0]  i_in_sum,
    input  logic [WIDTH:0]  i_in_sub,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [WIDTH-1:0] o_out_a,
    output logic [WIDTH-1:0] o_out_b,
    output logic            o_out_err,
    output logic [ERRW-1:0] o_err_count
);

    // Entry type at this instance's width.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             err;
    } entry_t;

    localparam logic [ERRW-1:0] ErrMax = '1;

    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_dif;
    entry_t         w_dec;
    entry_t         w_head;
    logic           w_in_ready;
    logic           w_accept;

    logic [ERRW-1:0] r_err_count;

    // Decode: both sums wrap mod 2^(WIDTH+1); dropping bit 0 halves them.
    always_comb begin
        w_add     = i_in_sum + i_in_sub;
        w_dif     = i_in_sum - i_in_sub;
        w_dec.a   = w_add[WIDTH:1];
        w_dec.b   = w_dif[WIDTH:1];
        w_dec.err = i_in_sum[0] ^ i_in_sub[0];
    end

    assign w_accept = i_in_valid && w_in_ready;

    // Saturating count of accepted words that failed the parity check.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_dec.err && (r_err_count != ErrMax)) begin
            r_err_count <= r_err_count + ERRW'(1);
        end
    end

    sdd_fifo2 #(
        .entry_t (entry_t)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push_valid (i_in_valid),
        .o_push_ready (w_in_ready),
        .i_push_data  (w_dec),
        .o_pop_valid  (o_out_valid),
        .i_pop_ready  (i_out_ready),
        .o_pop_data   (w_head)
    );

    assign o_in_ready  = w_in_ready;
    assign o_out_a     = w_head.a;
    assign o_out_b     = w_head.b;
    assign o_out_err   = w_head.err;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_sum_diff_decoder.sv
// Directed bench for sum_diff_decoder with hand-computed expectations.
module tb_sum_diff_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_sum;
    logic [4:0] in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic       out_err;
    logic [7:0] err_count;

    int checks;
    int failures;

    sum_diff_decoder #(
        .WIDTH (4),
        .ERRW  (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_sum    (in_sum),
        .i_in_sub    (in_sub),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_a     (out_a),
        .o_out_b     (out_b),
        .o_out_err   (out_err),
        .o_err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [4:0] s, input logic [4:0] d);
        in_valid = 1'b1;
        in_sum   = s;
        in_sub   = d;
    endtask

    initial begin
        logic [3:0] ea;
        logic [3:0] eb;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_sub    = '0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // a=9, b=3
        offer(5'd12, 5'd6);
        tick();
        check("w93_valid", out_valid, 1);
        check("w93_a", out_a, 9);
        check("w93_b", out_b, 3);
        check("w93_err", out_err, 0);

        // a=2, b=5: negative difference, accepted while head pops
        offer(5'd7, 5'b11101);
        tick();
        check("w25_valid", out_valid, 1);
        check("w25_a", out_a, 2);
        check("w25_b", out_b, 5);
        check("w25_err", out_err, 0);
        check("w25_in_ready", in_ready, 1);

        // Parity error word
        offer(5'd7, 5'd4);
        tick();
        check("werr_a", out_a, 5);
        check("werr_b", out_b, 1);
        check("werr_err", out_err, 1);
        check("werr_count", err_count, 1);

        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // Backpressure: three offers, only two accepted
        out_ready = 1'b0;
        offer(5'd12, 5'd6);
        tick();
        check("bp1_in_ready", in_ready, 1);
        offer(5'd7, 5'b11101);
        tick();
        check("bp2_in_ready", in_ready, 0);
        check("bp2_a", out_a, 9);
        offer(5'd7, 5'd4);
        tick();
        check("bp3_in_ready", in_ready, 0);
        check("bp3_a_stable", out_a, 9);
        check("bp3_b_stable", out_b, 3);
        check("bp3_count", err_count, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_pop1_valid", out_valid, 1);
        check("bp_pop1_a", out_a, 2);
        check("bp_pop1_b", out_b, 5);
        check("bp_pop1_in_ready", in_ready, 1);
        tick();
        check("bp_pop2_valid", out_valid, 0);

        // Back-to-back stream of 16 words
        for (int i = 0; i < 16; i++) begin
            ea = 4'(i);
            eb = 4'(15 - i);
            offer(5'(ea) + 5'(eb), 5'(ea) - 5'(eb));
            tick();
            check("stream_in_ready", in_ready, 1);
            check("stream_valid", out_valid, 1);
            check("stream_a", out_a, ea);
            check("stream_b", out_b, eb);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", out_valid, 0);

        // 300 parity errors: counter starts at 1, saturates at 255
        offer(5'd1, 5'd0);
        for (int i = 0; i < 253; i++) tick();
        check("sat_254", err_count, 254);
        tick();
        check("sat_255", err_count, 255);
        for (int i = 0; i < 46; i++) tick();
        check("sat_hold", err_count, 255);
        in_valid = 1'b0;
        tick();

        // Fill queue, then reset mid-operation
        out_ready = 1'b0;
        offer(5'd12, 5'd6);
        tick();
        offer(5'd7, 5'b11101);
        tick();
        check("fill_in_ready", in_ready, 0);
        check("fill_valid", out_valid, 1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_count", err_count, 0);
        check("mrst_in_ready", in_ready, 0);
        check("mrst_a", out_a, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mrel_in_ready", in_ready, 1);
        check("mrel_valid", out_valid, 0);
        tick();
        check("mrel_no_stale", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
